// File: rtl/character_sprite_fetcher_pkg.sv
// Shared character constants: sprite geometry, display ids, colour key and sprite ROM contents.
// The ROM image is generated by sprite_rom_word so the table is fixed at elaboration.
package character_sprite_fetcher_pkg;

   localparam int SPRITE_W_DEF = 32;
   localparam int SPRITE_H_DEF = 32;
   localparam int NUM_SPRITES_DEF = 7;
   localparam int COORD_WIDTH_DEF = 10;
   localparam logic [11:0] TRANSPARENT_RGB_DEF = 12'hF0F;

   typedef enum logic [2:0] {
      IDLE_DIS_1      = 3'd0,
      IDLE_DIS_2      = 3'd1,
      WALK_DIS_1      = 3'd2,
      WALK_DIS_2      = 3'd3,
      JUMP_DIS        = 3'd4,
      HURT_DIS        = 3'd5,
      SAFE_GROUND_DIS = 3'd6
   } display_id_e;

   // Every address congruent to 3 mod 7 holds the colour key, so each sprite row has see-through pixels.
   function automatic logic [11:0] sprite_rom_word(input logic [31:0] addr);
      if (addr % 32'd7 == 32'd3) begin
         return TRANSPARENT_RGB_DEF;
      end
      return 12'(addr * 32'd37 + (addr >> 5) * 32'd11);
   endfunction

endpackage

// File: rtl/character_sprite_fetcher_rom.sv
// character_sprite_rom: sprite image store, address in, registered 12-bit colour out (one-cycle latency).
module character_sprite_rom
   import character_sprite_fetcher_pkg::*;
#(
   parameter int ADDR_W = 13
) (
   input  logic              sys_clk,
   input  logic [ADDR_W-1:0] rom_addr,
   output logic [11:0]       rom_data
);

   always_ff @(posedge sys_clk) begin
      rom_data <= sprite_rom_word(32'(rom_addr));
   end

endmodule

// File: rtl/character_sprite_fetcher.sv
// Character sprite pixel fetcher: per-frame position/id latch, 3-cycle pixel pipeline and hit counter.
// Build option: define SPRITE_MIRROR_EN to flip sprite columns when the character faces left.
module character_sprite_fetcher
   import character_sprite_fetcher_pkg::*;
#(
   parameter int          SPRITE_W        = SPRITE_W_DEF,
   parameter int          SPRITE_H        = SPRITE_H_DEF,
   parameter int          NUM_SPRITES     = NUM_SPRITES_DEF,
   parameter int          COORD_WIDTH     = COORD_WIDTH_DEF,
   parameter logic [11:0] TRANSPARENT_RGB = TRANSPARENT_RGB_DEF
) (
   input  logic                   sys_clk,
   input  logic                   sys_rst_n,
   input  logic                   frame_start,
   input  logic [2:0]             char_display_id,
   input  logic                   facing_left,
   input  logic [COORD_WIDTH-1:0] char_x,
   input  logic [COORD_WIDTH-1:0] char_y,
   input  logic                   pixel_valid,
   input  logic [COORD_WIDTH-1:0] pixel_x,
   input  logic [COORD_WIDTH-1:0] pixel_y,
   output logic                   out_valid,
   output logic                   sprite_hit,
   output logic [11:0]            sprite_rgb,
   output logic [10:0]            hit_count
);

   localparam int XW     = $clog2(SPRITE_W);
   localparam int YW     = $clog2(SPRITE_H);
   localparam int ADDR_W = $clog2(NUM_SPRITES * SPRITE_W * SPRITE_H);
   localparam int CW1    = COORD_WIDTH + 1;

   logic [2:0]             id_q;
   logic                   face_q;
   logic [COORD_WIDTH-1:0] cx_q;
   logic [COORD_WIDTH-1:0] cy_q;

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         id_q   <= '0;
         face_q <= 1'b0;
         cx_q   <= '0;
         cy_q   <= '0;
      end else if (frame_start) begin
         id_q   <= (32'(char_display_id) < 32'(NUM_SPRITES)) ? char_display_id : 3'd0;
         face_q <= facing_left;
         cx_q   <= char_x;
         cy_q   <= char_y;
      end
   end

   // Box test at one extra bit so char_x + SPRITE_W never wraps past the screen edge.
   logic [CW1-1:0] px_e, py_e, cx_e, cy_e;
   logic           in_box_c;
   logic [XW-1:0]  dx_lo, col_c;
   logic [YW-1:0]  dy_lo;

   assign px_e = {1'b0, pixel_x};
   assign py_e = {1'b0, pixel_y};
   assign cx_e = {1'b0, cx_q};
   assign cy_e = {1'b0, cy_q};

   assign in_box_c = (px_e >= cx_e) && (px_e < cx_e + CW1'(SPRITE_W)) &&
                     (py_e >= cy_e) && (py_e < cy_e + CW1'(SPRITE_H));

   assign dx_lo = pixel_x[XW-1:0] - cx_q[XW-1:0];
   assign dy_lo = pixel_y[YW-1:0] - cy_q[YW-1:0];

`ifdef SPRITE_MIRROR_EN
   assign col_c = face_q ? (XW'(SPRITE_W - 1) - dx_lo) : dx_lo;
`else
   logic unused_face;
   assign unused_face = face_q;
   assign col_c = dx_lo;
`endif

   logic              v1, v2, v3;
   logic              in_box1, in_box2, in_box3;
   logic [XW-1:0]     col1;
   logic [YW-1:0]     row1;
   logic [2:0]        id1;
   logic [ADDR_W-1:0] addr2;
   logic [11:0]       rom_data;

   // id travels with the pixel so a frame_start mid-pipeline cannot change an in-flight address.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         v1      <= 1'b0;
         v2      <= 1'b0;
         v3      <= 1'b0;
         in_box1 <= 1'b0;
         in_box2 <= 1'b0;
         in_box3 <= 1'b0;
         col1    <= '0;
         row1    <= '0;
         id1     <= '0;
         addr2   <= '0;
      end else begin
         v1      <= pixel_valid;
         in_box1 <= in_box_c;
         col1    <= col_c;
         row1    <= dy_lo;
         id1     <= id_q;
         v2      <= v1;
         in_box2 <= in_box1;
         addr2   <= ADDR_W'(id1) * ADDR_W'(SPRITE_W * SPRITE_H) +
                    ADDR_W'(row1) * ADDR_W'(SPRITE_W) + ADDR_W'(col1);
         v3      <= v2;
         in_box3 <= in_box2;
      end
   end

   character_sprite_rom #(
      .ADDR_W (ADDR_W)
   ) u_rom (
      .sys_clk  (sys_clk),
      .rom_addr (addr2),
      .rom_data (rom_data)
   );

   logic hit_c;
   assign hit_c      = v3 && in_box3 && (rom_data != TRANSPARENT_RGB);
   assign out_valid  = v3;
   assign sprite_hit = hit_c;
   assign sprite_rgb = hit_c ? rom_data : 12'h000;

   logic [10:0] hit_cnt;

   // A hit coinciding with frame_start belongs to the frame that is just beginning.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         hit_cnt   <= '0;
         hit_count <= '0;
      end else if (frame_start) begin
         hit_count <= hit_cnt;
         hit_cnt   <= {10'd0, hit_c};
      end else if (hit_c && (hit_cnt != 11'h7FF)) begin
         hit_cnt <= hit_cnt + 11'd1;
      end
   end

endmodule

// File: tb/tb_character_sprite_fetcher.sv
// Self-checking bench for character_sprite_fetcher: behavioural per-pixel model plus directed literal checks.
module tb_character_sprite_fetcher;

   logic        sys_clk = 1'b0;
   logic        sys_rst_n;
   logic        frame_start;
   logic [2:0]  char_display_id;
   logic        facing_left;
   logic [9:0]  char_x, char_y;
   logic        pixel_valid;
   logic [9:0]  pixel_x, pixel_y;
   logic        out_valid;
   logic        sprite_hit;
   logic [11:0] sprite_rgb;
   logic [10:0] hit_count;

   int checks = 0;
   int failures = 0;

   typedef struct {
      bit          v;
      bit          hit;
      logic [11:0] rgb;
   } exp_t;

   exp_t q[$];
   int   m_id, m_cx, m_cy, m_cnt, m_hc;
   bit   m_face, cur_hit;
   int   opx[$], opy[$];

   character_sprite_fetcher dut (
      .sys_clk         (sys_clk),
      .sys_rst_n       (sys_rst_n),
      .frame_start     (frame_start),
      .char_display_id (char_display_id),
      .facing_left     (facing_left),
      .char_x          (char_x),
      .char_y          (char_y),
      .pixel_valid     (pixel_valid),
      .pixel_x         (pixel_x),
      .pixel_y         (pixel_y),
      .out_valid       (out_valid),
      .sprite_hit      (sprite_hit),
      .sprite_rgb      (sprite_rgb),
      .hit_count       (hit_count)
   );

   always #5 sys_clk = ~sys_clk;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
      end
   endtask

   function automatic logic [11:0] rom_model(input int a);
      if (a % 7 == 3) return 12'hF0F;
      return 12'((a * 37 + (a / 32) * 11) & 'hFFF);
   endfunction

   function automatic exp_t model_pixel(input int id, input bit face, input int cx, input int cy,
                                        input int px, input int py);
      exp_t e;
      int col;
      logic [11:0] d;
      e.v = 1'b1;
      e.hit = 1'b0;
      e.rgb = 12'h000;
      if (px >= cx && px < cx + 32 && py >= cy && py < cy + 32) begin
         col = px - cx;
`ifdef SPRITE_MIRROR_EN
         if (face) col = 31 - (px - cx);
`endif
         d = rom_model(id * 1024 + (py - cy) * 32 + col);
         e.hit = (d != 12'hF0F);
         e.rgb = e.hit ? d : 12'h000;
      end
      return e;
   endfunction

   function automatic void reseed();
      exp_t z;
      z.v = 0; z.hit = 0; z.rgb = 0;
      q.delete();
      q.push_back(z);
      q.push_back(z);
      m_id = 0; m_face = 0; m_cx = 0; m_cy = 0;
      m_cnt = 0; m_hc = 0; cur_hit = 0;
   endfunction

   task automatic model_loop();
      exp_t e;
      reseed();
      forever begin
         @(posedge sys_clk or negedge sys_rst_n);
         if (!sys_rst_n) begin
            reseed();
         end else begin
            if (frame_start) begin
               m_hc = m_cnt;
               m_cnt = cur_hit ? 1 : 0;
            end else if (cur_hit && m_cnt < 2047) begin
               m_cnt++;
            end
            e = model_pixel(m_id, m_face, m_cx, m_cy, int'(pixel_x), int'(pixel_y));
            e.v = pixel_valid;
            if (!pixel_valid) begin
               e.hit = 0;
               e.rgb = 0;
            end
            q.push_back(e);
            if (frame_start) begin
               m_id = (char_display_id < 3'd7) ? int'(char_display_id) : 0;
               m_face = facing_left;
               m_cx = int'(char_x);
               m_cy = int'(char_y);
            end
            #1;
            e = q.pop_front();
            check("m_out_valid", out_valid, e.v);
            check("m_sprite_hit", sprite_hit, e.hit);
            check("m_sprite_rgb", sprite_rgb, e.rgb);
            check("m_hit_count", hit_count, m_hc);
            cur_hit = e.v && e.hit;
         end
      end
   endtask

   task automatic new_frame(input int id, input bit face, input int cx, input int cy);
      @(negedge sys_clk);
      char_display_id = 3'(id);
      facing_left = face;
      char_x = 10'(cx);
      char_y = 10'(cy);
      frame_start = 1'b1;
      pixel_valid = 1'b0;
      @(negedge sys_clk);
      frame_start = 1'b0;
   endtask

   // Drives one pixel and returns half a cycle after its result appears.
   task automatic one_pixel(input int px, input int py);
      @(negedge sys_clk);
      pixel_valid = 1'b1;
      pixel_x = 10'(px);
      pixel_y = 10'(py);
      @(negedge sys_clk);
      pixel_valid = 1'b0;
      repeat (2) @(negedge sys_clk);
   endtask

   task automatic check_out(input string name, input bit v, input bit hit, input logic [11:0] rgb);
      check({name, "_valid"}, out_valid, v);
      check({name, "_hit"}, sprite_hit, hit);
      check({name, "_rgb"}, sprite_rgb, rgb);
   endtask

   initial begin
      sys_rst_n = 1'b0;
      frame_start = 0; char_display_id = 0; facing_left = 0;
      char_x = 0; char_y = 0; pixel_valid = 0; pixel_x = 0; pixel_y = 0;
      fork
         model_loop();
      join_none
      repeat (3) @(negedge sys_clk);
      check("rst_out_valid", out_valid, 0);
      check("rst_sprite_hit", sprite_hit, 0);
      check("rst_sprite_rgb", sprite_rgb, 0);
      check("rst_hit_count", hit_count, 0);
      sys_rst_n = 1'b1;
      repeat (2) @(negedge sys_clk);

      // id 2 at (100,50), first pixel of the sprite
      new_frame(2, 1, 100, 50);
      one_pixel(100, 50);
`ifdef SPRITE_MIRROR_EN
      check_out("id2_origin", 1, 1, 12'hF3B);
`else
      check_out("id2_origin", 1, 1, 12'hAC0);
`endif
      one_pixel(132, 50);
      check_out("right_edge", 1, 0, 12'h000);
      one_pixel(99, 50);
      check_out("left_edge", 1, 0, 12'h000);
      one_pixel(131, 50);

      new_frame(0, 0, 100, 50);
      one_pixel(103, 50);
      check_out("key_pixel", 1, 0, 12'h000);

      new_frame(0, 0, 1000, 50);
      one_pixel(5, 50);
      check_out("no_wrap", 1, 0, 12'h000);
      one_pixel(1001, 50);
      check_out("near_edge", 1, 1, 12'h025);

      new_frame(7, 0, 200, 100);
      one_pixel(201, 100);
      check_out("id7_as_0", 1, 1, 12'h025);

      @(negedge sys_clk);
      char_display_id = 3'd3;
      char_x = 10'd0;
      one_pixel(201, 100);
      check_out("mid_frame_id", 1, 1, 12'h025);

      // frame_start together with a pixel: pixel still sees the old frame
      @(negedge sys_clk);
      char_display_id = 3'd2; char_x = 10'd300; frame_start = 1'b1;
      pixel_valid = 1'b1; pixel_x = 10'd201; pixel_y = 10'd100;
      @(negedge sys_clk);
      frame_start = 1'b0; pixel_valid = 1'b0;
      repeat (2) @(negedge sys_clk);
      check_out("fs_coincide", 1, 1, 12'h025);

      // 40 opaque hits in one frame
      for (int dy = 0; dy < 32; dy++)
         for (int dx = 0; dx < 32; dx++)
            if (opx.size() < 40 && model_pixel(2, 0, 100, 50, 100 + dx, 50 + dy).hit) begin
               opx.push_back(100 + dx);
               opy.push_back(50 + dy);
            end
      new_frame(2, 0, 100, 50);
      for (int i = 0; i < 40; i++) begin
         @(negedge sys_clk);
         pixel_valid = 1'b1; pixel_x = 10'(opx[i]); pixel_y = 10'(opy[i]);
      end
      @(negedge sys_clk);
      pixel_valid = 1'b0;
      repeat (4) @(negedge sys_clk);
      new_frame(2, 0, 100, 50);
      check("hit_count_40", hit_count, 40);

      // saturation
      for (int i = 0; i < 2100; i++) begin
         @(negedge sys_clk);
         pixel_valid = 1'b1; pixel_x = 10'(opx[i % 40]); pixel_y = 10'(opy[i % 40]);
      end
      @(negedge sys_clk);
      pixel_valid = 1'b0;
      repeat (4) @(negedge sys_clk);
      new_frame(0, 0, 0, 0);
      check("hit_count_sat", hit_count, 2047);
      new_frame(0, 0, 0, 0);
      check("hit_count_clr", hit_count, 0);

      // randomized traffic with a mid-frame reset in the middle
      for (int n = 0; n < 3000; n++) begin
         @(negedge sys_clk);
         if (n == 1500) begin
            @(posedge sys_clk);
            #3;
            sys_rst_n = 1'b0;
            #1;
            check("mid_rst_valid", out_valid, 0);
            check("mid_rst_hit", sprite_hit, 0);
            check("mid_rst_rgb", sprite_rgb, 0);
            check("mid_rst_count", hit_count, 0);
            pixel_valid = 1'b0; frame_start = 1'b0;
            repeat (2) @(negedge sys_clk);
            sys_rst_n = 1'b1;
            @(negedge sys_clk);
         end
         frame_start = ($urandom_range(0, 49) == 0);
         if ($urandom_range(0, 29) == 0) begin
            char_display_id = 3'($urandom_range(0, 7));
            facing_left = 1'($urandom_range(0, 1));
            char_x = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(980, 1023))
                                                 : 10'($urandom_range(0, 1023));
            char_y = 10'($urandom_range(0, 1000));
         end
         pixel_valid = ($urandom_range(0, 4) != 0);
         if ($urandom_range(0, 7) == 0) begin
            pixel_x = 10'($urandom_range(0, 1023));
            pixel_y = 10'($urandom_range(0, 1023));
         end else begin
            pixel_x = 10'((int'(char_x) + int'($urandom_range(0, 40)) - 4) & 1023);
            pixel_y = 10'((int'(char_y) + int'($urandom_range(0, 40)) - 4) & 1023);
         end
      end
      @(negedge sys_clk);
      pixel_valid = 1'b0; frame_start = 1'b0;
      repeat (5) @(negedge sys_clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
